// File: rtl/wd_supervisor.sv
// Watchdog supervisor: arms, runs, trips, cools down and locks out a watchdog_timer,
// muting the RF path whenever the watchdog is not actively supervising.
module wd_supervisor #(
  parameter int N_SRC       = 4,
  parameter int ARM_DELAY   = 16,
  parameter int COOLDOWN    = 1024,
  parameter int MAX_RETRIES = 3,
  parameter int CW          = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sys_enable,
  input  logic             sw_clear,
  input  logic [N_SRC-1:0] src_alive,
  input  logic             wd_warning,
  input  logic             wd_triggered,
  output logic             wd_enable,
  output logic             wd_force_reset,
  output logic             wd_heartbeat,
  output logic             rf_mute,
  output logic             lockout,
  output logic [1:0]       retry_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_WARN = 3'd3,
    ST_TRIP = 3'd4,
    ST_COOL = 3'd5,
    ST_LOCK = 3'd6
  } state_t;

  localparam logic [CW-1:0] ARM_LOAD  = CW'(ARM_DELAY - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CW-1:0]    timer_q, timer_d;
  logic [1:0]       retry_q, retry_d, retry_inc;
  logic [N_SRC-1:0] seen_q, seen_d, seen_n;
  logic             hb_q, hb_d;
  logic             en_q, en_d;
  logic             frc_q, frc_d;
  logic             mute_q, mute_d;
  logic             lock_q, lock_d;

  // {enable, force_reset, mute} for a given state
  function automatic logic [2:0] decode_outs(input state_t s);
    case (s)
      ST_ARM:  decode_outs = 3'b111;
      ST_RUN:  decode_outs = 3'b100;
      ST_WARN: decode_outs = 3'b100;
      default: decode_outs = 3'b011;
    endcase
  endfunction

  // Saturating trip counter increment
  always_comb begin
    if (retry_q >= RETRY_MAX) begin
      retry_inc = retry_q;
    end else begin
      retry_inc = retry_q + 2'd1;
    end
  end

  // Next-state, delay timer and retry bookkeeping
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    if (!sys_enable && (state_q != ST_LOCK)) begin
      state_d = ST_IDLE;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sys_enable) begin
            state_d = ST_ARM;
            timer_d = ARM_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARM, ST_COOL: begin
          if (timer_q == {CW{1'b0}}) begin
            state_d = ST_RUN;
            if (state_q == ST_COOL) begin
              state_d = ST_ARM;
              timer_d = ARM_LOAD;
            end else begin
              timer_d = timer_q;
            end
          end else begin
            timer_d = timer_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          if (wd_triggered) begin
            state_d = ST_TRIP;
          end else if (wd_warning) begin
            state_d = ST_WARN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_WARN: begin
          if (wd_triggered) begin
            state_d = ST_TRIP;
          end else if (!wd_warning) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WARN;
          end
        end
        ST_TRIP: begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_MAX) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_COOL;
            timer_d = COOL_LOAD;
          end
        end
        ST_LOCK: begin
          if (sw_clear) begin
            state_d = ST_IDLE;
            retry_d = 2'd0;
          end else begin
            state_d = ST_LOCK;
          end
        end
        default: begin
          state_d = ST_IDLE;
          retry_d = 2'd0;
        end
      endcase
    end
  end

  // Heartbeat round: each source must check in once; completing bits close the current round
  always_comb begin
    seen_n = seen_q | src_alive;
    if ((state_q == ST_RUN) || (state_q == ST_WARN)) begin
      if (&seen_n) begin
        hb_d   = 1'b1;
        seen_d = {N_SRC{1'b0}};
      end else begin
        hb_d   = 1'b0;
        seen_d = seen_n;
      end
    end else begin
      hb_d   = 1'b0;
      seen_d = {N_SRC{1'b0}};
    end
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_comb begin
    {en_d, frc_d, mute_d} = decode_outs(state_d);
    lock_d = (state_d == ST_LOCK);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      timer_q <= {CW{1'b0}};
      retry_q <= 2'd0;
      seen_q  <= {N_SRC{1'b0}};
      hb_q    <= 1'b0;
      en_q    <= 1'b0;
      frc_q   <= 1'b1;
      mute_q  <= 1'b1;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      seen_q  <= seen_d;
      hb_q    <= hb_d;
      en_q    <= en_d;
      frc_q   <= frc_d;
      mute_q  <= mute_d;
      lock_q  <= lock_d;
    end
  end

  assign wd_enable      = en_q;
  assign wd_force_reset = frc_q;
  assign wd_heartbeat   = hb_q;
  assign rf_mute        = mute_q;
  assign lockout        = lock_q;
  assign retry_count    = retry_q;
  assign state          = state_q;

endmodule

// File: tb/tb_wd_supervisor.sv
// Directed self-checking bench for wd_supervisor: arming, heartbeat aggregation,
// trip/cooldown/lockout sequencing, sys_enable drop and mid-run reset.
module tb_wd_supervisor;

  localparam int ST_IDLE = 0;
  localparam int ST_ARM  = 1;
  localparam int ST_RUN  = 2;
  localparam int ST_WARN = 3;
  localparam int ST_TRIP = 4;
  localparam int ST_COOL = 5;
  localparam int ST_LOCK = 6;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sys_enable;
  logic       sw_clear;
  logic [3:0] src_alive;
  logic       wd_warning;
  logic       wd_triggered;
  logic       wd_enable;
  logic       wd_force_reset;
  logic       wd_heartbeat;
  logic       rf_mute;
  logic       lockout;
  logic [1:0] retry_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  wd_supervisor #(
    .N_SRC(4), .ARM_DELAY(16), .COOLDOWN(1024), .MAX_RETRIES(3), .CW(16)
  ) dut (
    .clk(clk), .rstn(rstn), .sys_enable(sys_enable), .sw_clear(sw_clear),
    .src_alive(src_alive), .wd_warning(wd_warning), .wd_triggered(wd_triggered),
    .wd_enable(wd_enable), .wd_force_reset(wd_force_reset), .wd_heartbeat(wd_heartbeat),
    .rf_mute(rf_mute), .lockout(lockout), .retry_count(retry_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {state, enable, force_reset, mute, lockout}
  function automatic logic [31:0] status();
    return {25'd0, state, wd_enable, wd_force_reset, rf_mute, lockout};
  endfunction

  function automatic logic [31:0] expect_st(input int st, input logic [3:0] outs);
    logic [2:0] s;
    s = 3'(st);
    return {25'd0, s, outs};
  endfunction

  // Called after the first ARM cycle has been observed
  task automatic arm_to_run(input string tag);
    for (int i = 0; i < 15; i++) begin
      step();
      check_eq({tag, "_arm"}, status(), expect_st(ST_ARM, 4'b1110));
    end
    step();
    check_eq({tag, "_run"}, status(), expect_st(ST_RUN, 4'b1000));
  endtask

  // Called after the first COOL cycle has been observed
  task automatic cool_to_arm(input string tag);
    for (int i = 0; i < 1023; i++) begin
      step();
      check_eq({tag, "_cool"}, {29'd0, state}, ST_COOL);
    end
    check_eq({tag, "_cool_outs"}, status(), expect_st(ST_COOL, 4'b0110));
    step();
    check_eq({tag, "_rearm"}, status(), expect_st(ST_ARM, 4'b1110));
  endtask

  initial begin
    rstn = 1'b0; sys_enable = 1'b0; sw_clear = 1'b0; src_alive = 4'b0000;
    wd_warning = 1'b0; wd_triggered = 1'b0;
    step(); step();
    check_eq("rst_status", status(), expect_st(ST_IDLE, 4'b0110));
    check_eq("rst_hb", {31'd0, wd_heartbeat}, 32'd0);
    check_eq("rst_retry", {30'd0, retry_count}, 32'd0);

    rstn = 1'b1;
    step();
    check_eq("idle_hold", status(), expect_st(ST_IDLE, 4'b0110));

    // Arming: 16 cycles in ARM, then RUN
    sys_enable = 1'b1;
    step();
    check_eq("t1_arm_first", status(), expect_st(ST_ARM, 4'b1110));
    arm_to_run("t1");

    // Two half-rounds combine into one heartbeat
    src_alive = 4'b0011;
    step();
    check_eq("t2_hb_half", {31'd0, wd_heartbeat}, 32'd0);
    src_alive = 4'b1100;
    step();
    check_eq("t2_hb_pulse", {31'd0, wd_heartbeat}, 32'd1);
    src_alive = 4'b0000;
    step();
    check_eq("t2_hb_single", {31'd0, wd_heartbeat}, 32'd0);
    // Repeated pulses from one source count once
    src_alive = 4'b0001; step();
    src_alive = 4'b0001; step();
    src_alive = 4'b0010; step();
    src_alive = 4'b0100; step();
    check_eq("t2_hb_dup", {31'd0, wd_heartbeat}, 32'd0);
    src_alive = 4'b1000; step();
    check_eq("t2_hb_dup_done", {31'd0, wd_heartbeat}, 32'd1);
    src_alive = 4'b0000; step();
    check_eq("t2_hb_clear", {31'd0, wd_heartbeat}, 32'd0);

    // Warning then trip: first retry, cooldown, re-arm
    wd_warning = 1'b1;
    step();
    check_eq("t3_warn", status(), expect_st(ST_WARN, 4'b1000));
    wd_triggered = 1'b1;
    step();
    check_eq("t3_trip", status(), expect_st(ST_TRIP, 4'b0110));
    wd_warning = 1'b0; wd_triggered = 1'b0;
    step();
    check_eq("t3_cool", status(), expect_st(ST_COOL, 4'b0110));
    check_eq("t3_retry", {30'd0, retry_count}, 32'd1);
    cool_to_arm("t3");
    arm_to_run("t3");

    // Warning and trigger together: trip wins
    wd_warning = 1'b1; wd_triggered = 1'b1;
    step();
    check_eq("t5_trip_wins", {29'd0, state}, ST_TRIP);
    wd_warning = 1'b0; wd_triggered = 1'b0;
    step();
    check_eq("t5_retry", {30'd0, retry_count}, 32'd2);
    cool_to_arm("t5");
    arm_to_run("t5");

    // Third trip locks out
    wd_triggered = 1'b1;
    step();
    check_eq("t4_trip3", {29'd0, state}, ST_TRIP);
    wd_triggered = 1'b0;
    step();
    check_eq("t4_lock", status(), expect_st(ST_LOCK, 4'b0111));
    check_eq("t4_retry_sat", {30'd0, retry_count}, 32'd3);
    sys_enable = 1'b0; step();
    check_eq("t4_lock_en0", status(), expect_st(ST_LOCK, 4'b0111));
    sys_enable = 1'b1; step();
    check_eq("t4_lock_en1", status(), expect_st(ST_LOCK, 4'b0111));
    sys_enable = 1'b0; sw_clear = 1'b1;
    step();
    check_eq("t4_clear", status(), expect_st(ST_IDLE, 4'b0110));
    check_eq("t4_clear_retry", {30'd0, retry_count}, 32'd0);
    sw_clear = 1'b0; sys_enable = 1'b1;
    step();
    check_eq("t6_arm", status(), expect_st(ST_ARM, 4'b1110));
    arm_to_run("t6");

    // sys_enable drop during cooldown
    wd_triggered = 1'b1; step();
    wd_triggered = 1'b0; step();
    check_eq("t6_cool", {29'd0, state}, ST_COOL);
    check_eq("t6_cool_retry", {30'd0, retry_count}, 32'd1);
    sys_enable = 1'b0;
    step();
    check_eq("t6_idle", status(), expect_st(ST_IDLE, 4'b0110));
    check_eq("t6_idle_retry", {30'd0, retry_count}, 32'd0);

    // Reset in WARN with a heartbeat about to complete
    sys_enable = 1'b1;
    step();
    check_eq("t6b_arm", {29'd0, state}, ST_ARM);
    arm_to_run("t6b");
    wd_warning = 1'b1;
    src_alive = 4'b0111;
    step();
    check_eq("t6b_warn", {29'd0, state}, ST_WARN);
    check_eq("t6b_warn_hb", {31'd0, wd_heartbeat}, 32'd0);
    src_alive = 4'b1000;
    rstn = 1'b0;
    step();
    check_eq("t6b_rst_status", status(), expect_st(ST_IDLE, 4'b0110));
    check_eq("t6b_rst_hb", {31'd0, wd_heartbeat}, 32'd0);
    check_eq("t6b_rst_retry", {30'd0, retry_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
